// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared encodings for the HI/LO multiply/divide unit: md_op
//               request codes, FSM states and the iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // One quotient/product bit is resolved per iteration edge
  localparam int MD_ITERS = 32;

  // Request codes carried on md_op; 3'd7 is reserved and behaves as NONE
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sign_fix
// Description : Combinational sign handling for the multiply/divide unit.
//               Extracts operand magnitudes at accept time and applies the
//               final conditional negation to a {HI,LO} result pair.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               signed_i,
  output logic [WIDTH-1:0]   mag_a_o,
  output logic [WIDTH-1:0]   mag_b_o,
  output logic               a_neg_o,
  output logic               b_neg_o,
  input  logic [2*WIDTH-1:0] fix_val_i,
  input  logic               fix_is_div_i,
  input  logic               fix_neg_hi_i,
  input  logic               fix_neg_lo_i,
  output logic [2*WIDTH-1:0] fix_res_o
);

  // Magnitudes: the most negative value maps onto itself, which is exactly
  // its unsigned magnitude, so no special case is required
  assign a_neg_o = signed_i & a_i[WIDTH-1];
  assign b_neg_o = signed_i & b_i[WIDTH-1];
  assign mag_a_o = a_neg_o ? -a_i : a_i;
  assign mag_b_o = b_neg_o ? -b_i : b_i;

  // Divide negates remainder (HI) and quotient (LO) independently;
  // multiply negates the whole 2*WIDTH product
  always_comb begin
    fix_res_o = fix_val_i;
    if (fix_is_div_i) begin
      if (fix_neg_hi_i) fix_res_o[2*WIDTH-1:WIDTH] = -fix_val_i[2*WIDTH-1:WIDTH];
      if (fix_neg_lo_i) fix_res_o[WIDTH-1:0]       = -fix_val_i[WIDTH-1:0];
    end else if (fix_neg_lo_i) begin
      fix_res_o = -fix_val_i;
    end
  end

endmodule : muldiv_sign_fix
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_unit
// Description : Iterative multiply/divide unit owning the HI and LO
//               registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO). Shift-add
//               multiply and restoring divide over operand magnitudes, one
//               bit per cycle, followed by a sign-fix cycle that writes HI/LO.
//               Optional build macro MULDIV_FAST_MULT_EN: MULT/MULTU finish
//               in a single cycle with a combinational product.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = MD_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_valid,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int c_cnt_w = $clog2(ITERS + 1);

  md_state_e            state_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 busy_q, done_q;
  logic [c_cnt_w-1:0]   cnt_q;
  // Multiply: {partial product, remaining multiplier bits}
  // Divide  : {partial remainder, dividend bits / quotient bits}
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q;       // multiplicand or divisor magnitude
  logic                 is_div_q;
  logic                 neg_hi_q;    // negate remainder
  logic                 neg_lo_q;    // negate product / quotient

  logic                 w_accept;
  logic                 w_is_signed;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic                 w_a_neg, w_b_neg;
  logic [2*WIDTH-1:0]   w_fix_val, w_fix_res;
  logic                 w_fix_is_div, w_fix_neg_hi, w_fix_neg_lo;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_div_trial;

  assign w_accept    = md_valid & ~busy_q &
                       (md_op != MD_NONE) & (md_op != 3'd7);
  assign w_is_signed = (md_op == MD_MULT) | (md_op == MD_DIV);

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .a_i          (src_a),
    .b_i          (src_b),
    .signed_i     (w_is_signed),
    .mag_a_o      (w_mag_a),
    .mag_b_o      (w_mag_b),
    .a_neg_o      (w_a_neg),
    .b_neg_o      (w_b_neg),
    .fix_val_i    (w_fix_val),
    .fix_is_div_i (w_fix_is_div),
    .fix_neg_hi_i (w_fix_neg_hi),
    .fix_neg_lo_i (w_fix_neg_lo),
    .fix_res_o    (w_fix_res)
  );

  // Select what the sign-fix stage operates on (fast product while idle)
  always_comb begin
    w_fix_val    = acc_q;
    w_fix_is_div = is_div_q;
    w_fix_neg_hi = neg_hi_q;
    w_fix_neg_lo = neg_lo_q;
`ifdef MULDIV_FAST_MULT_EN
    if (state_q == ST_IDLE) begin
      w_fix_val    = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
      w_fix_is_div = 1'b0;
      w_fix_neg_hi = 1'b0;
      w_fix_neg_lo = w_a_neg ^ w_b_neg;
    end
`endif
  end

  // One shift-add or restoring-divide step on the shared accumulator
  always_comb begin
    w_mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    w_div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
    acc_d       = acc_q;
    if (state_q == ST_MUL) begin
      acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
    end else if (state_q == ST_DIV) begin
      if (!w_div_trial[WIDTH]) acc_d = {w_div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                     acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, HI/LO ownership and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            case (md_op)
              MD_MTHI: hi_q <= src_a;
              MD_MTLO: lo_q <= src_a;
              MD_MULT, MD_MULTU: begin
`ifdef MULDIV_FAST_MULT_EN
                {hi_q, lo_q} <= w_fix_res;
                done_q       <= 1'b1;
`else
                state_q  <= ST_MUL;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                acc_q    <= {{WIDTH{1'b0}}, w_mag_b};
                opb_q    <= w_mag_a;
                is_div_q <= 1'b0;
                neg_hi_q <= 1'b0;
                neg_lo_q <= w_a_neg ^ w_b_neg;
`endif
              end
              MD_DIV, MD_DIVU: begin
                state_q  <= ST_DIV;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                acc_q    <= {{WIDTH{1'b0}}, w_mag_a};
                opb_q    <= w_mag_b;
                is_div_q <= 1'b1;
                // Divide by zero leaves an all-ones quotient and the dividend
                // magnitude as remainder; re-signing the remainder restores
                // the original dividend, and the quotient must stay all-ones
                neg_hi_q <= w_a_neg;
                neg_lo_q <= (w_a_neg ^ w_b_neg) & (src_b != '0);
              end
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + c_cnt_w'(1);
          if (cnt_q == c_cnt_w'(ITERS - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          {hi_q, lo_q} <= w_fix_res;
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          cnt_q        <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign md_busy = busy_q;
  assign md_done = done_q;
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;

endmodule : hilo_muldiv_unit
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_muldiv_unit
// Description : Scoreboard bench for hilo_muldiv_unit: directed corner cases
//               and random requests checked against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        md_valid = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        md_busy, md_done;
  logic [31:0] hi_out, lo_out;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  hilo_muldiv_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .md_valid (md_valid),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic, result as {HI,LO}
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      MD_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: every md_done pops one expected {HI,LO}
  always @(negedge clk) begin
    if (!rst && md_done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_done: got=done want=no_pending_op");
      end else begin
        chk("sb_hilo", {hi_out, lo_out}, sb_q.pop_front());
        chk("sb_done_busy", {63'b0, md_busy}, 64'd0);
      end
    end
  end

  // Called just after a falling edge; returns just after a falling edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit intrude);
    int n;
    int lat;
    bit is_md;
    is_md = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    md_valid = 1'b1;
    md_op    = op;
    src_a    = a;
    src_b    = b;
    if (is_md) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    md_valid = 1'b0;
    md_op    = 3'd0;
    @(negedge clk);
    if (op == MD_MTHI) begin
      model_hi = a;
      chk("mthi", {hi_out, lo_out}, {model_hi, model_lo});
      chk("mthi_busy", {63'b0, md_busy}, 64'd0);
    end else if (op == MD_MTLO) begin
      model_lo = a;
      chk("mtlo", {hi_out, lo_out}, {model_hi, model_lo});
      chk("mtlo_busy", {63'b0, md_busy}, 64'd0);
    end else if (is_md) begin
      lat = 33;
`ifdef MULDIV_FAST_MULT_EN
      if (op == MD_MULT || op == MD_MULTU) lat = 0;
`endif
      n = 0;
      while (md_busy && n < 100) begin
        chk("hold_hilo", {hi_out, lo_out}, {model_hi, model_lo});
        if (intrude) begin
          md_valid = 1'b1;
          md_op    = MD_MULT;
          src_a    = 32'd5;
          src_b    = 32'd5;
        end
        n++;
        @(negedge clk);
      end
      md_valid = 1'b0;
      md_op    = 3'd0;
      chk("busy_cycles", 64'(n), 64'(lat));
      {model_hi, model_lo} = exp;
    end else begin
      chk("none_hilo", {hi_out, lo_out}, {model_hi, model_lo});
      chk("none_busy", {62'b0, md_busy, md_done}, 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    chk("reset_state", {hi_out, lo_out}, 64'd0);
    chk("reset_flags", {62'b0, md_busy, md_done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(MD_MULT,  32'hFFFF_FFFE, 32'd3,         {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1'b1);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    issue(MD_DIVU,  32'd100,       32'd7,         {32'h0000_0002, 32'h0000_000E}, 1'b0);
    issue(MD_DIVU,  32'h1234_5678, 32'd0,         {32'h1234_5678, 32'hFFFF_FFFF}, 1'b0);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b0);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd0,         {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b0);
    issue(MD_MTHI,  32'hAAAA_5555, 32'd0, 64'd0, 1'b0);
    issue(MD_MTLO,  32'h0000_1234, 32'd0, 64'd0, 1'b0);
    issue(MD_NONE,  32'hDEAD_BEEF, 32'd1, 64'd0, 1'b0);
    issue(3'd7,     32'hDEAD_BEEF, 32'd1, 64'd0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      issue(op, a, b, ref_md(op, a, b), 1'b0);
    end

    // Asynchronous reset in the middle of a divide
    md_valid = 1'b1;
    md_op    = MD_DIVU;
    src_a    = 32'd100;
    src_b    = 32'd7;
    @(posedge clk);
    #1;
    md_valid = 1'b0;
    md_op    = 3'd0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_hilo", {hi_out, lo_out}, 64'd0);
    chk("async_rst_flags", {62'b0, md_busy, md_done}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(MD_MULTU, 32'd6, 32'd7, {32'd0, 32'd42}, 1'b0);

    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hilo_muldiv_unit
`default_nettype wire

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execution-side responder for the multiply/divide/HI-LO instruction group:
  - DIV, DIVU, MULT, MULTU
  - MTHI, MTLO, MFHI, MFLO
- The control decoder's outputs are turned into an md_op request that reaches this unit.
- Computes products and quotients iteratively and owns the architectural HI and LO registers.
- Drives md_busy so the pipeline stalls any dependent instruction (MFHI/MFLO or a new mul/div) until results land.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- ITERS, 32, iteration count for shift-add multiply and restoring divide. Must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- md_valid  input  1  request strobe from the execute stage.
- md_op  input  3  operation:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - 7 is reserved and treated as NONE.
- src_a  input  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data.
- src_b  input  WIDTH  rt value: multiplier or divisor.
- md_busy  output  1  high while an iterative operation is in flight. The pipeline must stall.
- md_done  output  1  one-cycle pulse in the cycle after HI/LO are updated by mul/div.
- hi_out  output  WIDTH  current HI register, for MFHI.
- lo_out  output  WIDTH  current LO register, for MFLO.

Behaviour:
- Reset (async, any time, including mid-operation):
  - HI=0, LO=0, FSM=IDLE.
  - md_busy=0, md_done=0.
  - Iteration counter and partial registers cleared.
  - The in-flight operation is discarded; HI/LO are not partially written.
- Acceptance: a request is accepted on a rising edge where md_valid=1, md_op≠NONE, and md_busy=0. Requests while md_busy=1 are ignored; the pipeline is required to hold them.
- MTHI/MTLO:
  - Written at the accept edge: HI<=src_a or LO<=src_a.
  - No busy cycle; visible on hi_out/lo_out the next cycle.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on an accepted MULT/MULTU.
  - IDLE -> DIV on an accepted DIV/DIVU.
  - MUL/DIV -> FIX after ITERS iteration edges.
  - FIX -> IDLE after one edge, which writes HI/LO.
- Accept-edge capture: operand magnitudes (abs value for signed ops), result-sign flags, and op type.
- Latency: accept at edge E0; iterate on E1..E32; FIX writes HI/LO at E33.
  - md_busy is high from after E0 through E33 (33 cycles).
  - md_done is high for the one cycle after E33.
- Multiply: 64-bit unsigned shift-add over magnitudes.
  - FIX negates the 64-bit product if the signed-op sign flags differ.
  - HI=product[63:32], LO=product[31:0].
- Divide: restoring division on magnitudes, one quotient bit per cycle.
  - Signed quotient is negative iff operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - LO=quotient, HI=remainder.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=src_a as captured (the original dividend, not its magnitude).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- hi_out/lo_out always reflect the registers. During busy they hold pre-operation values.
- A new request is accepted no earlier than the first cycle with md_busy=0, i.e. the same cycle md_done is high.

Optional Feature:
- MULDIV_FAST_MULT_EN.
- When defined:
  - MULT/MULTU compute with a single-cycle 64-bit combinational product.
  - HI/LO are written at the accept edge, md_busy stays 0, and md_done pulses the following cycle.
  - DIV is unchanged.
- When undefined: the 33-cycle iterative multiply described above.

Decomposition:
- Package muldiv_pkg holds:
  - md_op encodings: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - FSM state encodings.
  - MD_ITERS constant.
- One sub-module, muldiv_sign_fix (combinational):
  - Magnitude extraction on accept.
  - Conditional negation of the 64-bit product or of the quotient/remainder pair in FIX.

Test Plan:
- MULT src_a=0xFFFFFFFE, src_b=3 -> md_busy 33 cycles, then md_done; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7 (0xFFFFFFF9) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=0x0000000E, HI=0x00000002.
- DIVU 0x12345678 / 0 -> LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xAAAA5555, then next cycle MTLO 0x1234 -> hi_out/lo_out update one cycle after each, md_busy never asserts. A MULT issued while busy is ignored, and HI/LO match only the first op.
- Start DIVU 100/7, assert rst asynchronously at iteration 10 -> md_busy, md_done, HI, LO are 0 immediately. After release, a fresh MULTU 6×7 gives LO=42, HI=0.
